// File: rtl/exec_pkg.sv
// exec_pkg: shared data width, opcode encoding and FSM states for exec_unit.
// No ports. Used by exec_unit_if, exec_mul_seq and exec_unit.
package exec_pkg;
  localparam int W = 16;
  typedef enum logic [2:0] {
    OP_ADD = 3'b000, OP_SUB = 3'b001, OP_AND = 3'b010, OP_OR  = 3'b011,
    OP_SLT = 3'b100, OP_SLL = 3'b101, OP_SRL = 3'b110, OP_MUL = 3'b111
  } alu_op_t;
  typedef enum logic {IDLE, MUL_RUN} state_t;
endpackage

// File: rtl/exec_unit_if.sv
// exec_unit_if: issue-side handshake and register-file write-back bundle.
// master (issue stage): drives InValid, AluOp, OpA, OpB, DestIn, WrEnIn;
//   observes InReady, WriteData, WrAddr, RegWrite, Zero, Carry, Busy.
// slave (exec_unit): the reverse directions.
interface exec_unit_if;
  import exec_pkg::*;
  logic         InValid, InReady;
  alu_op_t      AluOp;
  logic [W-1:0] OpA, OpB, WriteData;
  logic [1:0]   DestIn, WrAddr;
  logic         WrEnIn, RegWrite, Zero, Carry, Busy;
  modport master (output InValid, AluOp, OpA, OpB, DestIn, WrEnIn,
                  input  InReady, WriteData, WrAddr, RegWrite, Zero, Carry, Busy);
  modport slave  (input  InValid, AluOp, OpA, OpB, DestIn, WrEnIn,
                  output InReady, WriteData, WrAddr, RegWrite, Zero, Carry, Busy);
endinterface

// File: rtl/exec_mul_seq.sv
// exec_mul_seq: 16-iteration shift-add multiplier producing the low W product bits.
// Ports: Clock, Reset (sync, active-high); start loads a/b; done is high during
// the cycle whose edge completes the last iteration; product is valid with done.
module exec_mul_seq
  import exec_pkg::*;
(
  input  logic         Clock,
  input  logic         Reset,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         done,
  output logic [W-1:0] product
);
  logic [W-1:0] acc, mcand, mplier;
  logic [3:0]   cnt;
  logic         run;
  // product is the accumulator after the iteration the next edge performs
  assign product = acc + (mplier[0] ? mcand : '0);
  assign done    = run && cnt == 4'd15;
  always_ff @(posedge Clock)
    if (Reset) begin
      run    <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (start) begin
      run    <= 1'b1;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= a;
      mplier <= b;
    end else if (run) begin
      acc    <= product;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 4'd1;
      run    <= !done;
    end
endmodule

// File: rtl/exec_unit.sv
// exec_unit: single-cycle ALU with optional iterative multiply, writing back to a register file.
// Ports: Clock, Reset (sync, active-high); bus (exec_unit_if.slave) carries issue
// handshake, operands, write-back strobe/data/address, flags and Busy.
// Macro EXEC_UNIT_MUL_EN: when defined MUL runs on exec_mul_seq over 16 cycles;
// when undefined MUL retires in one cycle with no write and cleared flags.
module exec_unit
  import exec_pkg::*;
(
  input  logic       Clock,
  input  logic       Reset,
  exec_unit_if.slave bus
);
`ifdef EXEC_UNIT_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif
  state_t       state, state_nxt;
  logic         accept, is_mul, mul_done, cy, wr, zf, cf, wen_q;
  logic [W-1:0] res, mul_prod, wdata;
  logic [1:0]   waddr, dest_q;
  logic [W:0]   sum, diff;
  assign sum          = {1'b0, bus.OpA} + {1'b0, bus.OpB};
  // bit W of the 17-bit difference is the unsigned borrow
  assign diff         = {1'b0, bus.OpA} - {1'b0, bus.OpB};
  assign bus.Busy     = state == MUL_RUN;
  assign bus.InReady  = state == IDLE;
  assign accept       = bus.InValid && bus.InReady;
  assign is_mul       = bus.AluOp == OP_MUL;
  assign bus.WriteData = wdata;
  assign bus.WrAddr   = waddr;
  assign bus.RegWrite = wr;
  assign bus.Zero     = zf;
  assign bus.Carry    = cf;
`ifdef EXEC_UNIT_MUL_EN
  exec_mul_seq u_mul (
    .Clock   (Clock),
    .Reset   (Reset),
    .start   (accept && is_mul),
    .a       (bus.OpA),
    .b       (bus.OpB),
    .done    (mul_done),
    .product (mul_prod)
  );
`else
  assign mul_done = 1'b0;
  assign mul_prod = '0;
`endif
  always_comb begin
    res = '0;
    cy  = 1'b0;
    case (bus.AluOp)
      OP_ADD:  {cy, res} = sum;
      OP_SUB:  {cy, res} = diff;
      OP_AND:  res = bus.OpA & bus.OpB;
      OP_OR:   res = bus.OpA | bus.OpB;
      OP_SLT:  res = {{(W-1){1'b0}}, $signed(bus.OpA) < $signed(bus.OpB)};
      OP_SLL:  res = bus.OpA << bus.OpB[3:0];
      OP_SRL:  res = bus.OpA >> bus.OpB[3:0];
      default: res = '0;
    endcase
  end
  always_comb begin
    state_nxt = state;
    if (state == IDLE)
      state_nxt = (accept && is_mul && MUL_EN) ? MUL_RUN : IDLE;
    else
      state_nxt = mul_done ? IDLE : MUL_RUN;
  end
  always_ff @(posedge Clock)
    state <= Reset ? IDLE : state_nxt;
  // Without the multiplier, MUL takes the single-cycle path: res is 0, no write, flags cleared.
  always_ff @(posedge Clock)
    if (Reset) begin
      wdata  <= '0;
      waddr  <= '0;
      wr     <= 1'b0;
      zf     <= 1'b0;
      cf     <= 1'b0;
      dest_q <= '0;
      wen_q  <= 1'b0;
    end else begin
      wr <= 1'b0;
      if (accept && !(MUL_EN && is_mul)) begin
        wdata <= res;
        waddr <= bus.DestIn;
        wr    <= bus.WrEnIn && bus.DestIn != 2'b00 && !is_mul;
        zf    <= res == '0 && !is_mul;
        cf    <= cy;
      end
      if (accept && is_mul) begin
        dest_q <= bus.DestIn;
        wen_q  <= bus.WrEnIn;
      end
      if (mul_done) begin
        wdata <= mul_prod;
        waddr <= dest_q;
        wr    <= wen_q && dest_q != 2'b00;
        zf    <= mul_prod == '0;
        cf    <= 1'b0;
      end
    end
endmodule

// File: tb/tb_exec_unit.sv
// tb_exec_unit: randomized and directed self-checking bench for exec_unit against an arithmetic reference model.
module tb_exec_unit;
  import exec_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  exec_unit_if bus();
  exec_unit dut (.Clock(clk), .Reset(rst), .bus(bus));

  // returns {carry, zero, result} from the architectural rules
  function automatic logic [17:0] model(input alu_op_t op, input logic [15:0] a, input logic [15:0] b);
    int unsigned s;
    logic [15:0] r;
    logic c, z;
    c = 1'b0;
    r = '0;
    case (op)
      OP_ADD: begin s = a + b; r = s[15:0]; c = s[16]; end
      OP_SUB: begin r = a - b; c = a < b; end
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      OP_SLT: r = ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
      OP_SLL: r = a << b[3:0];
      OP_SRL: r = a >> b[3:0];
      default: begin s = a * b; r = s[15:0]; end
    endcase
    z = r == 16'h0000;
`ifndef EXEC_UNIT_MUL_EN
    if (op == OP_MUL) begin r = '0; z = 1'b0; c = 1'b0; end
`endif
    return {c, z, r};
  endfunction

  task automatic drive(input logic v, input alu_op_t op, input logic [15:0] a, input logic [15:0] b,
                       input logic [1:0] d, input logic w);
    bus.InValid = v; bus.AluOp = op; bus.OpA = a; bus.OpB = b; bus.DestIn = d; bus.WrEnIn = w;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    drive(1'b0, OP_ADD, 16'h0, 16'h0, 2'd0, 1'b0);
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    drive(1'b0, OP_ADD, 16'h0, 16'h0, 2'd0, 1'b0);
    repeat (2) tick();
    checks++;
    if ({bus.RegWrite, bus.Busy, bus.Zero, bus.Carry, bus.WrAddr, bus.WriteData} !== 22'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0", {bus.RegWrite, bus.Busy, bus.Zero, bus.Carry, bus.WrAddr, bus.WriteData});
    end
    checks++;
    if (bus.InReady !== 1'b1) begin errors++; $display("FAIL reset_inready: got %b expected 1", bus.InReady); end
    drive(1'b1, OP_ADD, 16'hFFFF, 16'h0001, 2'd1, 1'b1);
    tick();
    checks++;
    if ({bus.RegWrite, bus.Zero, bus.Carry} !== 3'b000) begin
      errors++;
      $display("FAIL reset_dominates: got %b expected 000", {bus.RegWrite, bus.Zero, bus.Carry});
    end
    rst = 1'b0;
    drive(1'b0, OP_ADD, 16'h0, 16'h0, 2'd0, 1'b0);
    tick();
  endtask

  task automatic test_add_carry;
    drive(1'b1, OP_ADD, 16'hFFFF, 16'h0001, 2'd1, 1'b1);
    tick();
    checks++;
    if ({bus.WriteData, bus.WrAddr, bus.RegWrite, bus.Zero, bus.Carry} !== {16'h0000, 2'd1, 3'b111}) begin
      errors++;
      $display("FAIL add_wrap: got %h expected %h", {bus.WriteData, bus.WrAddr, bus.RegWrite, bus.Zero, bus.Carry},
               {16'h0000, 2'd1, 3'b111});
    end
    drive(1'b0, OP_ADD, 16'h0, 16'h0, 2'd0, 1'b0);
    tick();
    checks++;
    if ({bus.RegWrite, bus.Zero, bus.Carry} !== 3'b011) begin
      errors++;
      $display("FAIL idle_hold_flags: got %b expected 011", {bus.RegWrite, bus.Zero, bus.Carry});
    end
  endtask

  task automatic test_back_to_back;
    drive(1'b1, OP_SUB, 16'h0003, 16'h0005, 2'd1, 1'b1);
    tick();
    drive(1'b1, OP_SLT, 16'h0003, 16'h0005, 2'd2, 1'b1);
    checks++;
    if ({bus.RegWrite, bus.WrAddr, bus.WriteData, bus.Zero, bus.Carry} !== {1'b1, 2'd1, 16'hFFFE, 2'b01}) begin
      errors++;
      $display("FAIL b2b_sub: got %h expected %h", {bus.RegWrite, bus.WrAddr, bus.WriteData, bus.Zero, bus.Carry},
               {1'b1, 2'd1, 16'hFFFE, 2'b01});
    end
    tick();
    drive(1'b0, OP_ADD, 16'h0, 16'h0, 2'd0, 1'b0);
    checks++;
    if ({bus.RegWrite, bus.WrAddr, bus.WriteData, bus.Zero, bus.Carry} !== {1'b1, 2'd2, 16'h0001, 2'b00}) begin
      errors++;
      $display("FAIL b2b_slt: got %h expected %h", {bus.RegWrite, bus.WrAddr, bus.WriteData, bus.Zero, bus.Carry},
               {1'b1, 2'd2, 16'h0001, 2'b00});
    end
    tick();
    checks++;
    if (bus.RegWrite !== 1'b0) begin errors++; $display("FAIL b2b_strobe_end: got %b expected 0", bus.RegWrite); end
  endtask

  task automatic test_write_suppress;
    drive(1'b1, OP_ADD, 16'h0001, 16'h0001, 2'd3, 1'b1);
    tick();
    drive(1'b1, OP_ADD, 16'h8000, 16'h8000, 2'd0, 1'b1);
    tick();
    checks++;
    if ({bus.RegWrite, bus.Zero, bus.Carry} !== 3'b011) begin
      errors++;
      $display("FAIL r0_suppress: got %b expected 011", {bus.RegWrite, bus.Zero, bus.Carry});
    end
    drive(1'b1, OP_AND, 16'h00F0, 16'h0FF0, 2'd2, 1'b0);
    tick();
    drive(1'b0, OP_ADD, 16'h0, 16'h0, 2'd0, 1'b0);
    checks++;
    if ({bus.RegWrite, bus.WriteData, bus.Zero, bus.Carry} !== {1'b0, 16'h00F0, 2'b00}) begin
      errors++;
      $display("FAIL wren_suppress: got %h expected %h", {bus.RegWrite, bus.WriteData, bus.Zero, bus.Carry},
               {1'b0, 16'h00F0, 2'b00});
    end
  endtask

  task automatic test_random;
    logic v, w, z_h, c_h, exp_rw;
    alu_op_t op;
    logic [15:0] a, b;
    logic [1:0] d;
    logic [17:0] e;
    do_reset();
    z_h = 1'b0;
    c_h = 1'b0;
    for (int i = 0; i < 300; i++) begin
      v  = $urandom_range(0, 3) != 0;
      op = alu_op_t'($urandom_range(0, 6));
      a  = 16'($urandom);
      b  = ($urandom_range(0, 7) == 0) ? a : 16'($urandom);
      d  = 2'($urandom);
      w  = 1'($urandom);
      drive(v, op, a, b, d, w);
      tick();
      checks++;
      if (v) begin
        e = model(op, a, b);
        exp_rw = w && d != 2'd0;
        if ({bus.RegWrite, bus.WrAddr, bus.WriteData, bus.Zero, bus.Carry} !== {exp_rw, d, e[15:0], e[16], e[17]}) begin
          errors++;
          $display("FAIL random_%0d op=%0d a=%h b=%h: got %h expected %h", i, op, a, b,
                   {bus.RegWrite, bus.WrAddr, bus.WriteData, bus.Zero, bus.Carry}, {exp_rw, d, e[15:0], e[16], e[17]});
        end
        z_h = e[16];
        c_h = e[17];
      end else if ({bus.RegWrite, bus.Zero, bus.Carry} !== {1'b0, z_h, c_h}) begin
        errors++;
        $display("FAIL random_idle_%0d: got %b expected %b", i, {bus.RegWrite, bus.Zero, bus.Carry}, {1'b0, z_h, c_h});
      end
    end
    drive(1'b0, OP_ADD, 16'h0, 16'h0, 2'd0, 1'b0);
    tick();
  endtask

`ifdef EXEC_UNIT_MUL_EN
  task automatic run_mul(input logic [15:0] a, input logic [15:0] b, input logic [1:0] d, input logic w,
                         input logic noise);
    logic [17:0] e;
    e = model(OP_MUL, a, b);
    drive(1'b1, OP_MUL, a, b, d, w);
    tick();
    drive(noise, OP_ADD, 16'h0001, 16'h0002, 2'd1, 1'b1);
    for (int i = 0; i < 16; i++) begin
      checks++;
      if ({bus.Busy, bus.InReady, bus.RegWrite} !== 3'b100) begin
        errors++;
        $display("FAIL mul_busy_%0d: got %b expected 100", i, {bus.Busy, bus.InReady, bus.RegWrite});
      end
      tick();
    end
    drive(1'b0, OP_ADD, 16'h0, 16'h0, 2'd0, 1'b0);
    checks++;
    if ({bus.RegWrite, bus.WrAddr, bus.WriteData, bus.Zero, bus.Carry, bus.Busy, bus.InReady} !==
        {w && d != 2'd0, d, e[15:0], e[16], 3'b001}) begin
      errors++;
      $display("FAIL mul_result a=%h b=%h: got %h expected %h", a, b,
               {bus.RegWrite, bus.WrAddr, bus.WriteData, bus.Zero, bus.Carry, bus.Busy, bus.InReady},
               {w && d != 2'd0, d, e[15:0], e[16], 3'b001});
    end
    tick();
    checks++;
    if ({bus.RegWrite, bus.Busy} !== 2'b00) begin
      errors++;
      $display("FAIL mul_noise_ignored: got %b expected 00", {bus.RegWrite, bus.Busy});
    end
  endtask

  task automatic test_mul;
    run_mul(16'h0123, 16'h0010, 2'd2, 1'b1, 1'b1);
    run_mul(16'h1234, 16'h0000, 2'd3, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++)
      run_mul(16'($urandom), 16'($urandom), 2'($urandom), 1'($urandom), 1'($urandom));
  endtask

  task automatic test_reset_abort;
    int bad;
    drive(1'b1, OP_MUL, 16'h1234, 16'h5678, 2'd3, 1'b1);
    tick();
    drive(1'b0, OP_ADD, 16'h0, 16'h0, 2'd0, 1'b0);
    repeat (7) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({bus.RegWrite, bus.Busy, bus.InReady} !== 3'b001) begin
      errors++;
      $display("FAIL abort_state: got %b expected 001", {bus.RegWrite, bus.Busy, bus.InReady});
    end
    bad = 0;
    repeat (20) begin
      tick();
      if (bus.RegWrite !== 1'b0 || bus.Busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL abort_no_late_write: got %0d bad cycles expected 0", bad); end
  endtask
`else
  task automatic test_mul_disabled;
    int bad;
    drive(1'b1, OP_ADD, 16'hFFFF, 16'h0001, 2'd1, 1'b1);
    tick();
    drive(1'b1, OP_MUL, 16'h0003, 16'h0005, 2'd2, 1'b1);
    tick();
    drive(1'b1, OP_ADD, 16'h0002, 16'h0003, 2'd3, 1'b1);
    checks++;
    if ({bus.RegWrite, bus.Zero, bus.Carry, bus.Busy, bus.InReady} !== 5'b00001) begin
      errors++;
      $display("FAIL nomul_retire: got %b expected 00001", {bus.RegWrite, bus.Zero, bus.Carry, bus.Busy, bus.InReady});
    end
    tick();
    drive(1'b0, OP_ADD, 16'h0, 16'h0, 2'd0, 1'b0);
    checks++;
    if ({bus.RegWrite, bus.WrAddr, bus.WriteData, bus.Zero, bus.Carry} !== {1'b1, 2'd3, 16'h0005, 2'b00}) begin
      errors++;
      $display("FAIL nomul_next_add: got %h expected %h", {bus.RegWrite, bus.WrAddr, bus.WriteData, bus.Zero, bus.Carry},
               {1'b1, 2'd3, 16'h0005, 2'b00});
    end
    bad = 0;
    drive(1'b1, OP_MUL, 16'h0101, 16'h0202, 2'd1, 1'b1);
    repeat (16) begin
      tick();
      if (bus.Busy !== 1'b0 || bus.RegWrite !== 1'b0) bad++;
    end
    drive(1'b0, OP_ADD, 16'h0, 16'h0, 2'd0, 1'b0);
    checks++;
    if (bad != 0) begin errors++; $display("FAIL nomul_never_busy: got %0d bad cycles expected 0", bad); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    drive(1'b0, OP_ADD, 16'h0, 16'h0, 2'd0, 1'b0);
    test_reset();
    test_add_carry();
    test_back_to_back();
    test_write_suppress();
    test_random();
`ifdef EXEC_UNIT_MUL_EN
    test_mul();
    test_reset_abort();
`else
    test_mul_disabled();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
